// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: one outstanding instruction request, a holding register toward decode,
// and redirect handling with in-flight discard. Optional misaligned-redirect trap: PC_SEQ_MISALIGN_TRAP_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0100,
    parameter logic [31:0] PC_STEP   = 32'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_ir_valid,
    output logic [31:0] o_ir,
    output logic [31:0] o_ir_pc,
    input  logic        i_ir_ready,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic        i_stall,
    output logic [31:0] o_pc,
    output logic        o_misalign
);

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic [31:0] pc_inflight, pc_inflight_nx;
    logic [31:0] ir, ir_nx;
    logic [31:0] ir_pc, ir_pc_nx;
    logic        ir_valid, ir_valid_nx;
    logic        discard, discard_nx;
    logic        misalign, misalign_nx;
    logic [31:0] redirect_target;
    logic        redirect_misaligned;
    logic        granted;

`ifdef PC_SEQ_MISALIGN_TRAP_EN
    assign redirect_misaligned = |i_redirect_pc[1:0];
    assign redirect_target     = redirect_misaligned ? TRAP_VEC : i_redirect_pc;
`else
    // Low target bits are simply dropped when the trap is not built in.
    logic unused_lowbits;
    assign unused_lowbits      = ^i_redirect_pc[1:0];
    assign redirect_misaligned = 1'b0;
    assign redirect_target     = {i_redirect_pc[31:2], 2'b00};
`endif

    assign o_imem_req  = (state == REQ) && !i_stall;
    assign o_imem_addr = pc;
    assign granted     = o_imem_req && i_imem_gnt;

    assign o_pc       = pc;
    assign o_ir       = ir;
    assign o_ir_pc    = ir_pc;
    assign o_ir_valid = ir_valid;
    assign o_misalign = misalign;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= BOOT;
            pc          <= RESET_VEC;
            pc_inflight <= 32'h0;
            ir          <= 32'h0;
            ir_pc       <= 32'h0;
            ir_valid    <= 1'b0;
            discard     <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            pc_inflight <= pc_inflight_nx;
            ir          <= ir_nx;
            ir_pc       <= ir_pc_nx;
            ir_valid    <= ir_valid_nx;
            discard     <= discard_nx;
            misalign    <= misalign_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        pc_inflight_nx = pc_inflight;
        ir_nx          = ir;
        ir_pc_nx       = ir_pc;
        ir_valid_nx    = ir_valid;
        discard_nx     = discard;
        misalign_nx    = 1'b0;

        case (state)
            BOOT: state_nx = REQ;
            REQ: begin
                if (granted) begin
                    pc_inflight_nx = pc;
                    pc_nx          = pc + PC_STEP;
                    state_nx       = WAIT;
                end
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    if (discard) begin
                        discard_nx = 1'b0;
                        state_nx   = REQ;
                    end else begin
                        ir_nx       = i_imem_rdata;
                        ir_pc_nx    = pc_inflight;
                        ir_valid_nx = 1'b1;
                        state_nx    = HOLD;
                    end
                end
            end
            HOLD: begin
                if (i_ir_ready) begin
                    ir_valid_nx = 1'b0;
                    state_nx    = REQ;
                end
            end
            default: state_nx = BOOT;
        endcase

        // Redirect overrides everything above; a response still owed by memory must be swallowed.
        if (i_redirect) begin
            pc_nx       = redirect_target;
            ir_valid_nx = 1'b0;
            ir_nx       = ir;
            ir_pc_nx    = ir_pc;
            misalign_nx = redirect_misaligned;
            if ((state == WAIT && !i_imem_rvalid) || (state == REQ && granted)) begin
                discard_nx = 1'b1;
                state_nx   = WAIT;
            end else begin
                if (state == WAIT) begin
                    discard_nx = 1'b0;
                end
                state_nx = REQ;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: memory model with configurable latency and a scoreboard
// of granted fetches that redirects flush and decode acceptances pop.
module tb_pc_sequencer;

    localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
    localparam logic [31:0] EXP_MIS_PC = TRAP_VEC;
    localparam logic        EXP_MIS    = 1'b1;
`else
    localparam logic [31:0] EXP_MIS_PC = 32'h0000_0100;
    localparam logic        EXP_MIS    = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt = 1'b1;
    logic        i_imem_rvalid = 1'b0;
    logic [31:0] i_imem_rdata = 32'h0;
    logic        o_ir_valid;
    logic [31:0] o_ir;
    logic [31:0] o_ir_pc;
    logic        i_ir_ready = 1'b1;
    logic        i_redirect = 1'b0;
    logic [31:0] i_redirect_pc = 32'h0;
    logic        i_stall = 1'b0;
    logic [31:0] o_pc;
    logic        o_misalign;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t        exp_q[$];
    rsp_t        mem_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          mem_lat = 1;
    int          accepts = 0;
    int          grants = 0;
    int          last_gnt = -1;
    bit          pace_check = 1'b0;
    logic [31:0] model_pc = 32'h0;
    logic [31:0] last_acc_pc = 32'h0;
    logic        exp_mis = 1'b0;

    pc_sequencer dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_ir_valid    (o_ir_valid),
        .o_ir          (o_ir),
        .o_ir_pc       (o_ir_pc),
        .i_ir_ready    (i_ir_ready),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .i_stall       (i_stall),
        .o_pc          (o_pc),
        .o_misalign    (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] memData(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock: memory drives at the falling edge, then the bench checks and updates its model
    // with exactly the values the DUT will capture on the next rising edge.
    task automatic applyStimulus();
        exp_t e;
        @(negedge i_clk);
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = 32'h0;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_q[0].data;
            mem_q.delete(0);
        end
        #1;
        checkOutput("pc", o_pc, model_pc);
        checkOutput("misalign", {31'b0, o_misalign}, {31'b0, exp_mis});
        if (i_stall) checkOutput("stall_req", {31'b0, o_imem_req}, 32'd0);
        if (o_imem_req) checkOutput("addr", o_imem_addr, model_pc);
        if (o_ir_valid && i_ir_ready) begin
            accepts++;
            last_acc_pc = o_ir_pc;
            checkOutput("ir_pending", exp_q.size(), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("ir_pc", o_ir_pc, e.pc);
                checkOutput("ir_data", o_ir, e.data);
            end
        end
        exp_mis = 1'b0;
        if (o_imem_req && i_imem_gnt) begin
            if (pace_check && last_gnt >= 0) checkOutput("pace", cyc - last_gnt, 32'd3);
            last_gnt = cyc;
            grants++;
            exp_q.push_back('{model_pc, memData(model_pc)});
            mem_q.push_back('{cyc + mem_lat, memData(model_pc)});
            model_pc = model_pc + 32'd4;
        end
        if (i_redirect) begin
            exp_q.delete();
            last_gnt = -1;
`ifdef PC_SEQ_MISALIGN_TRAP_EN
            if (i_redirect_pc[1:0] != 2'b00) begin
                model_pc = TRAP_VEC;
                exp_mis  = 1'b1;
            end else begin
                model_pc = i_redirect_pc;
            end
`else
            model_pc = {i_redirect_pc[31:2], 2'b00};
`endif
        end
        @(posedge i_clk);
        cyc++;
        #1;
        i_redirect = 1'b0;
    endtask

    task automatic applyReset();
        i_rst_n       = 1'b0;
        i_redirect    = 1'b0;
        i_stall       = 1'b0;
        i_imem_rvalid = 1'b0;
        mem_q.delete();
        exp_q.delete();
        model_pc = 32'h0;
        exp_mis  = 1'b0;
        last_gnt = -1;
        #1;
        checkOutput("rst_pc", o_pc, 32'h0);
        checkOutput("rst_req", {31'b0, o_imem_req}, 32'd0);
        checkOutput("rst_irv", {31'b0, o_ir_valid}, 32'd0);
        checkOutput("rst_ir", o_ir, 32'h0);
        checkOutput("rst_irpc", o_ir_pc, 32'h0);
        checkOutput("rst_mis", {31'b0, o_misalign}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1;
        checkOutput("boot_req", {31'b0, o_imem_req}, 32'd0);
    endtask

    initial begin
        int          n;
        int          a0;
        int          g;
        logic [31:0] saved;

        #2;
        applyReset();

        // Sequential fetch at best-case pacing
        pace_check = 1'b1;
        for (int i = 0; i < 20; i++) applyStimulus();
        pace_check = 1'b0;
        checkOutput("seq_accepts", {31'b0, accepts >= 6}, 32'd1);
        checkOutput("seq_lastpc", {31'b0, last_acc_pc >= 32'h14}, 32'd1);

        // Stall while requesting
        n = 0;
        while (!o_imem_req && n < 10) begin applyStimulus(); n++; end
        checkOutput("reach_req", {31'b0, o_imem_req}, 32'd1);
        saved   = model_pc;
        i_stall = 1'b1;
        for (int i = 0; i < 5; i++) applyStimulus();
        checkOutput("stall_pc", o_pc, saved);
        i_stall = 1'b0;
        #1;
        checkOutput("resume_req", {31'b0, o_imem_req}, 32'd1);
        checkOutput("resume_addr", o_imem_addr, saved);

        // Redirect while waiting, stale response arrives two cycles later
        mem_lat = 3;
        g = grants;
        n = 0;
        while (grants == g && n < 10) begin applyStimulus(); n++; end
        checkOutput("reach_wait", {31'b0, grants > g}, 32'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0200;
        applyStimulus();
        mem_lat = 1;
        a0 = accepts;
        n = 0;
        while (accepts == a0 && n < 20) begin applyStimulus(); n++; end
        checkOutput("redir_wait_pc", last_acc_pc, 32'h0000_0200);

        // Redirect coincident with the grant for 0x40
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0040;
        applyStimulus();
        n = 0;
        while (!(o_imem_req && o_imem_addr == 32'h40) && n < 20) begin applyStimulus(); n++; end
        checkOutput("reach_0x40", {31'b0, o_imem_req && o_imem_addr == 32'h40}, 32'd1);
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0300;
        applyStimulus();
        a0 = accepts;
        n = 0;
        while (accepts == a0 && n < 20) begin applyStimulus(); n++; end
        checkOutput("redir_gnt_pc", last_acc_pc, 32'h0000_0300);

        // PC wrap at the top of the address space
        i_redirect    = 1'b1;
        i_redirect_pc = 32'hFFFF_FFFC;
        applyStimulus();
        g = grants;
        n = 0;
        while (grants == g && n < 20) begin applyStimulus(); n++; end
        checkOutput("wrap", o_pc, 32'h0000_0000);
        a0 = accepts;
        n = 0;
        while (accepts == a0 && n < 20) begin applyStimulus(); n++; end
        checkOutput("wrap_irpc", last_acc_pc, 32'hFFFF_FFFC);

        // Decode back-pressure, then redirect together with the accept
        i_ir_ready = 1'b0;
        n = 0;
        while (!o_ir_valid && n < 20) begin applyStimulus(); n++; end
        checkOutput("reach_hold", {31'b0, o_ir_valid}, 32'd1);
        saved = (exp_q.size() > 0) ? exp_q[0].data : 32'hxxxx_xxxx;
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("hold_valid", {31'b0, o_ir_valid}, 32'd1);
        checkOutput("hold_ir", o_ir, saved);
        i_ir_ready    = 1'b1;
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0500;
        a0 = accepts;
        applyStimulus();
        checkOutput("hold_redir_xfer", accepts, a0 + 1);
        a0 = accepts;
        n = 0;
        while (accepts == a0 && n < 20) begin applyStimulus(); n++; end
        checkOutput("after_hold_pc", last_acc_pc, 32'h0000_0500);

        // Misaligned redirect
        i_redirect    = 1'b1;
        i_redirect_pc = 32'h0000_0102;
        applyStimulus();
        checkOutput("mis_pc", o_pc, EXP_MIS_PC);
        checkOutput("mis_pulse", {31'b0, o_misalign}, {31'b0, EXP_MIS});
        applyStimulus();
        checkOutput("mis_once", {31'b0, o_misalign}, 32'd0);

        // Asynchronous reset in the middle of traffic
        for (int i = 0; i < 4; i++) applyStimulus();
        applyReset();
        a0 = accepts;
        for (int i = 0; i < 12; i++) applyStimulus();
        checkOutput("post_rst_run", {31'b0, accepts >= a0 + 3}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
